data_ram_ctrl: RTL and testbench
================================

DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, 10, address width in bits.
REQ-003 Parameter DEPTH, 281, number of words; SHALL satisfy DEPTH <= 2**ADDR_WIDTH.
REQ-004 Port clock  input  1  sole clock; all state updates on posedge clock.
REQ-005 Port reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-006 Port request  input  1  access request, qualified by ready.
REQ-007 Port writeEnable  input  1  1 = write, 0 = read, qualified by request.
REQ-008 Port address  input  ADDR_WIDTH  word address.
REQ-009 Port dataC  input  DATA_WIDTH  write data.
REQ-010 Port byteEnable  input  DATA_WIDTH/8  per-byte write mask; bit i covers dataC[8i+7:8i].
REQ-011 Port ready  output  1  high when requests are accepted.
REQ-012 Port readValid  output  1  one-cycle pulse; dataRAMOutput valid.
REQ-013 Port dataRAMOutput  output  DATA_WIDTH  registered response word.
REQ-014 Port addressError  output  1  pulses with readValid for an out-of-range access.

Function
REQ-015 The controller SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 In CLEAR, the controller SHALL write zero to word clearAddress each cycle, incrementing from 0; after writing DEPTH-1 it SHALL enter READY on the next edge. CLEAR SHALL last exactly DEPTH cycles.
REQ-017 ready SHALL be 0 in CLEAR and 1 in READY.
REQ-018 A request SHALL be accepted on a posedge where request=1 and ready=1; requests while ready=0 SHALL be dropped, with no queuing and no response.
REQ-019 Accepted write: for every byte i with byteEnable[i]=1, the controller SHALL replace that byte of the addressed word with the dataC byte; other bytes SHALL be unchanged.
REQ-020 Each accepted access SHALL produce readValid=1 exactly one cycle later, with dataRAMOutput equal to the word after any write in that access (write-first). Latency is 1.
REQ-021 Throughput SHALL be one access per cycle; back-to-back accesses to the same address SHALL see the previous write.
REQ-022 A write with byteEnable all zero SHALL leave memory unchanged and SHALL return the current word.
REQ-023 An access with address >= DEPTH SHALL NOT modify memory, SHALL return dataRAMOutput=0, and SHALL pulse addressError with readValid.
REQ-024 When readValid=0, dataRAMOutput SHALL hold its last value and addressError SHALL be 0.

Reset
REQ-025 Reset SHALL force the FSM to CLEAR and clearAddress to 0. After reset: ready=0, readValid=0, addressError=0, dataRAMOutput=0.
REQ-026 Reset during CLEAR SHALL restart clearing from address 0.
REQ-027 Reset in the cycle after an acceptance SHALL suppress the pending readValid.
REQ-028 Memory contents SHALL NOT be reset directly; only the CLEAR sweep zeroes them.

Structure
REQ-029 Package data_ram_pkg SHALL hold the FSM state enum and a BYTES = DATA_WIDTH/8 helper constant.
REQ-030 Storage SHALL be a sub-module data_ram_array: a single-port, byte-enabled, synchronous-write DEPTH x DATA_WIDTH array. data_ram_ctrl SHALL hold the FSM, clear counter, range check, and response registers.
REQ-031 The write port SHALL be muxed between the clear sweep and user accesses; in CLEAR, only the sweep SHALL drive it.

Verification
REQ-032 Reset released, DEPTH=281 -> ready=0 for exactly 281 cycles, then 1; a read of address 280 returns 0.
REQ-033 Write 0xDEADBEEF to address 9 with byteEnable=1111, then write 0x000000AA with byteEnable=0001, then read 9 -> the responses are 0xDEADBEEF, 0xDEADBEAA, 0xDEADBEAA, each with readValid one cycle after acceptance.
REQ-034 Access address 300 (write, then read) -> memory unchanged, dataRAMOutput=0, addressError=1 for one cycle per access.
REQ-035 Assert reset at clear cycle 100, release it -> the full 281-cycle clear restarts; a request during clear gets no readValid.
REQ-036 Write to address 12 then read 12 on consecutive cycles, followed by a reset in the cycle after the read is accepted -> the write response is correct, the read readValid is suppressed, and CLEAR re-runs.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared types and constants for the data RAM controller and its storage array.
package data_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ramState_t;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int BYTES              = DATA_WIDTH_DEFAULT / 8;

    function automatic int bytesOf(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// DEPTH x DATA_WIDTH single-port array: byte-masked synchronous write, combinational read.
// Out-of-range addresses never write and read back as zero.
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 281
) (
    input  logic                    clock,
    input  logic                    writeEnable,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH/8-1:0] byteMask,
    output logic [DATA_WIDTH-1:0]   readData
);

    localparam int NUM_BYTES = bytesOf(DATA_WIDTH);
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  inRange;
    logic [IDX_W-1:0]      idx;

    always_comb begin
        inRange  = ({1'b0, address} < DEPTH_L);
        idx      = address[IDX_W-1:0];
        readData = '0;
        if (inRange) begin
            readData = mem[idx];
        end
    end

    always_ff @(posedge clock) begin
        if (writeEnable && inRange) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (byteMask[i]) begin
                    mem[idx][8*i +: 8] <= writeData[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Zero-sweeping RAM controller: 1-cycle write-first response, one access per cycle.
// No backpressure on responses; requests while ready=0 are dropped.
module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 281
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    request,
    input  logic                    writeEnable,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   dataC,
    input  logic [DATA_WIDTH/8-1:0] byteEnable,
    output logic                    ready,
    output logic                    readValid,
    output logic [DATA_WIDTH-1:0]   dataRAMOutput,
    output logic                    addressError
);

    localparam int NUM_BYTES = bytesOf(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    ramState_t             state;
    logic [ADDR_WIDTH-1:0] clearAddress;
    logic                  readyQ;
    logic                  validQ;
    logic                  errorQ;
    logic [DATA_WIDTH-1:0] dataQ;

    logic                  accept;
    logic                  inRange;
    logic                  arrWe;
    logic [ADDR_WIDTH-1:0] arrAddr;
    logic [DATA_WIDTH-1:0] arrData;
    logic [NUM_BYTES-1:0]  arrMask;
    logic [DATA_WIDTH-1:0] readData;
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        accept  = request && readyQ;
        inRange = ({1'b0, address} < DEPTH_L);

        // The sweep owns the port for the whole of CLEAR.
        if (state == CLEAR) begin
            arrWe   = 1'b1;
            arrAddr = clearAddress;
            arrData = '0;
            arrMask = '1;
        end else begin
            arrWe   = accept && writeEnable && inRange;
            arrAddr = address;
            arrData = dataC;
            arrMask = byteEnable;
        end

        merged = readData;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (writeEnable && byteEnable[i]) begin
                merged[8*i +: 8] = dataC[8*i +: 8];
            end
        end
    end

    data_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clock       (clock),
        .writeEnable (arrWe),
        .address     (arrAddr),
        .writeData   (arrData),
        .byteMask    (arrMask),
        .readData    (readData)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= CLEAR;
            clearAddress <= '0;
            readyQ       <= 1'b0;
            validQ       <= 1'b0;
            errorQ       <= 1'b0;
            dataQ        <= '0;
        end else begin
            validQ <= accept;
            errorQ <= accept && !inRange;
            if (accept) begin
                dataQ <= inRange ? merged : '0;
            end
            case (state)
                CLEAR: begin
                    if (clearAddress == LAST_ADDR) begin
                        state        <= READY;
                        readyQ       <= 1'b1;
                        clearAddress <= '0;
                    end else begin
                        clearAddress <= clearAddress + 1'b1;
                    end
                end
                READY: begin
                    readyQ <= 1'b1;
                end
                default: begin
                    state  <= CLEAR;
                    readyQ <= 1'b0;
                end
            endcase
        end
    end

    // A reset raised while a response is on the wires kills that response immediately.
    assign ready         = readyQ;
    assign readValid     = validQ && !reset;
    assign addressError  = errorQ && !reset;
    assign dataRAMOutput = dataQ;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: directed accesses push expectations, a negedge monitor pops them.
module tb_data_ram_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 281;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          request = 1'b0;
    logic          writeEnable = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] dataC = '0;
    logic [3:0]    byteEnable = '0;
    logic          ready;
    logic          readValid;
    logic [DW-1:0] dataRAMOutput;
    logic          addressError;

    data_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .request       (request),
        .writeEnable   (writeEnable),
        .address       (address),
        .dataC         (dataC),
        .byteEnable    (byteEnable),
        .ready         (ready),
        .readValid     (readValid),
        .dataRAMOutput (dataRAMOutput),
        .addressError  (addressError)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } resp_t;

    resp_t       expQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        rstSeen = 1'b1;
    logic [31:0] lastOut = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) rstSeen <= reset;

    always @(negedge clock) begin
        resp_t e;
        if (reset) begin
            check("valid gated by reset", {31'b0, readValid}, 32'd0);
        end else if (readValid) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected response: got data %h err %0b, wanted none (t=%0t)",
                         dataRAMOutput, addressError, $time);
            end else begin
                e = expQ.pop_front();
                check("resp data", dataRAMOutput, e.dat);
                check("resp addressError", {31'b0, addressError}, {31'b0, e.err});
                lastOut = e.dat;
            end
        end else begin
            if (rstSeen) lastOut = '0;
            check("idle hold data", dataRAMOutput, lastOut);
            check("idle addressError", {31'b0, addressError}, 32'd0);
        end
    end

    task automatic access(input logic we, input int addr, input logic [31:0] d,
                          input logic [3:0] be, input logic [31:0] expD,
                          input logic expE, input logic track);
        request     = 1'b1;
        writeEnable = we;
        address     = AW'(addr);
        dataC       = d;
        byteEnable  = be;
        if (track) expQ.push_back(resp_t'{dat: expD, err: expE});
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        request = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulseReset();
        request = 1'b0;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic countClear(input string name);
        int cnt = 0;
        for (int guard = 0; guard < 2000; guard++) begin
            @(negedge clock);
            if (ready) break;
            cnt++;
        end
        @(posedge clock);
        #1;
        check(name, cnt, DEPTH);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset ready", {31'b0, ready}, 32'd0);
        check("reset readValid", {31'b0, readValid}, 32'd0);
        check("reset addressError", {31'b0, addressError}, 32'd0);
        check("reset dataRAMOutput", dataRAMOutput, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        countClear("initial clear length");

        access(1'b0, 280, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1);
        access(1'b1, 9,   32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1);
        access(1'b1, 9,   32'h000000AA, 4'b0001, 32'hDEADBEAA, 1'b0, 1'b1);
        access(1'b0, 9,   32'h0,        4'b0000, 32'hDEADBEAA, 1'b0, 1'b1);
        access(1'b1, 9,   32'hFFFFFFFF, 4'b0000, 32'hDEADBEAA, 1'b0, 1'b1);
        access(1'b1, 9,   32'h11223344, 4'b1010, 32'h11AD33AA, 1'b0, 1'b1);
        access(1'b1, 300, 32'h12345678, 4'b1111, 32'h0,        1'b1, 1'b1);
        access(1'b0, 300, 32'h0,        4'b0000, 32'h0,        1'b1, 1'b1);
        access(1'b0, 44,  32'h0,        4'b0000, 32'h0,        1'b0, 1'b1);
        access(1'b0, 9,   32'h0,        4'b0000, 32'h11AD33AA, 1'b0, 1'b1);
        idle(2);
        access(1'b1, 280,  32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b1);
        access(1'b1, 280,  32'h00770000, 4'b0100, 32'hCA77F00D, 1'b0, 1'b1);
        access(1'b0, 280,  32'h0,        4'b0000, 32'hCA77F00D, 1'b0, 1'b1);
        access(1'b1, 1023, 32'h55555555, 4'b1111, 32'h0,        1'b1, 1'b1);
        idle(2);

        // Reset partway through a sweep, with a dropped request inside the sweep.
        pulseReset();
        idle(100);
        check("ready during clear", {31'b0, ready}, 32'd0);
        access(1'b0, 5, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0);
        pulseReset();
        countClear("restarted clear length");

        // Reset on the cycle the read response would appear.
        access(1'b1, 12, 32'h5A5AA5A5, 4'b1111, 32'h5A5AA5A5, 1'b0, 1'b1);
        access(1'b0, 12, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b0);
        pulseReset();
        countClear("clear after late reset");
        access(1'b0, 12,  32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);
        access(1'b0, 9,   32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);
        access(1'b0, 280, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);
        idle(3);

        check("scoreboard drained", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
